// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The stream source/memory side uses `master`; the loader uses `slave`.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a length-prefixed big-endian word
// stream and holds the CPU in reset until done. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 10  // must not exceed 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reload,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  imem_loader_if.slave        bus
);

  typedef enum logic [2:0] {
    S_CNT_HI,
    S_CNT_LO,
    S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [15:0] word_total;
  logic [15:0] words_done;
  logic [23:0] assembly;
  logic [1:0]  byte_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_sum;
`endif

  logic        take;
  logic        last_write;
  logic [16:0] count_now;

  assign take       = bus.byte_valid & bus.byte_ready;
  assign last_write = bus.mem_we && (words_done + 16'd1 == word_total);
  assign count_now  = {1'b0, cnt_hi, bus.byte_data};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_CNT_HI;
      cnt_hi         <= '0;
      word_total     <= '0;
      words_done     <= '0;
      assembly       <= '0;
      byte_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_sum        <= '0;
`endif
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.byte_ready <= 1'b1;
      cpu_reset      <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      if (bus.mem_we) begin
        bus.mem_addr <= bus.mem_addr + 1'b1;
        words_done   <= words_done + 16'd1;
      end

      case (state)
        S_CNT_HI: if (take) begin
          cnt_hi <= bus.byte_data;
          state  <= S_CNT_LO;
        end

        S_CNT_LO: if (take) begin
          word_total <= count_now[15:0];
          if (count_now == 17'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= S_CSUM;
`else
            state          <= S_DONE;
            done           <= 1'b1;
            cpu_reset      <= 1'b0;
            bus.byte_ready <= 1'b0;
`endif
          end else if (count_now > CAPACITY) begin
            state          <= S_ERR;
            error          <= 1'b1;
            bus.byte_ready <= 1'b0;
          end else begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (last_write) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            // A byte taken during the final write cycle is already the checksum.
            if (!take) begin
              state <= S_CSUM;
            end else if (bus.byte_data == xor_sum) begin
              state          <= S_DONE;
              done           <= 1'b1;
              cpu_reset      <= 1'b0;
              bus.byte_ready <= 1'b0;
            end else begin
              state          <= S_ERR;
              error          <= 1'b1;
              bus.byte_ready <= 1'b0;
            end
`else
            state          <= S_DONE;
            done           <= 1'b1;
            cpu_reset      <= 1'b0;
            bus.byte_ready <= 1'b0;
`endif
          end else if (take) begin
            assembly <= {assembly[15:0], bus.byte_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_sum  <= xor_sum ^ bus.byte_data;
`endif
            if (byte_cnt == 2'd3) begin
              bus.mem_wdata <= {assembly, bus.byte_data};
              bus.mem_we    <= 1'b1;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: if (take) begin
          bus.byte_ready <= 1'b0;
          if (bus.byte_data == xor_sum) begin
            state     <= S_DONE;
            done      <= 1'b1;
            cpu_reset <= 1'b0;
          end else begin
            state <= S_ERR;
            error <= 1'b1;
          end
        end
`endif

        default: if (reload) begin  // S_DONE / S_ERR
          state          <= S_CNT_HI;
          words_done     <= '0;
          word_total     <= '0;
          assembly       <= '0;
          byte_cnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_sum        <= '0;
`endif
          bus.mem_addr   <= '0;
          bus.byte_ready <= 1'b1;
          cpu_reset      <= 1'b1;
          done           <= 1'b0;
          error          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: normal load, gapped load,
// oversize count, empty image, mid-load reset and (if enabled) checksum.
module tb_imem_loader;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic reload = 1'b0;
  logic cpu_reset, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .reload    (reload),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write log and write-data stability monitor.
  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic          we_early;
  logic [31:0]   wd_early;

  always @(posedge clk) begin
    #1;
    we_early = bus.mem_we;
    wd_early = bus.mem_wdata;
  end

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_wdata);
      if (we_early === 1'b1) check("wdata stable", bus.mem_wdata, wd_early);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [7:0] stim[$];

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int  n;
    bit  acc;
    n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (n) begin
      bus.byte_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = bus.byte_ready;
      @(posedge clk); #1;
    end
    bus.byte_valid = 1'b0;
    if (!acc) check("send timeout", 32'd0, 32'd1);
  endtask

  task automatic send_stim(input int gap_max);
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], gap_max);
  endtask

  task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < stim.size(); i++) x = x ^ stim[i];
    stim.push_back(x);
`endif
  endtask

  task automatic wait_final(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = done | error;
    end
    if (!seen) check({tag, " final timeout"}, 32'd0, 32'd1);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    check("reload cpu_reset", cpu_reset, 1'b1);
    check("reload done", done, 1'b0);
    check("reload error", error, 1'b0);
    check("reload ready", bus.byte_ready, 1'b1);
    check("reload addr", bus.mem_addr, 0);
  endtask

  task automatic load_prog1();
    stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
    add_csum();
  endtask

  task automatic check_prog1_writes(input string tag);
    check({tag, " nwrites"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, " addr0"}, wr_addr[0], 0);
      check({tag, " data0"}, wr_data[0], 32'h2008_0005);
      check({tag, " addr1"}, wr_addr[1], 1);
      check({tag, " data1"}, wr_data[1], 32'hAC08_0000);
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset values while held and after release
    #12;
    check("rst cpu_reset", cpu_reset, 1'b1);
    check("rst done", done, 1'b0);
    check("rst error", error, 1'b0);
    check("rst ready", bus.byte_ready, 1'b1);
    check("rst we", bus.mem_we, 1'b0);
    check("rst addr", bus.mem_addr, 0);
    check("rst wdata", bus.mem_wdata, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle cpu_reset", cpu_reset, 1'b1);
    check("idle done", done, 1'b0);
    check("idle ready", bus.byte_ready, 1'b1);
    check("idle addr", bus.mem_addr, 0);

    // Two-word image, one byte per cycle
    load_prog1();
    wr_addr.delete(); wr_data.delete();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_stim(0);
    @(negedge clk);
`else
    send_stim(0);
    @(negedge clk);
    check("p1 last we", bus.mem_we, 1'b1);
    check("p1 not done yet", done, 1'b0);
    @(negedge clk);
`endif
    check("p1 done", done, 1'b1);
    check("p1 cpu_reset", cpu_reset, 1'b0);
    check("p1 ready", bus.byte_ready, 1'b0);
    check("p1 addr", bus.mem_addr, 2);
    check_prog1_writes("p1");

    // Same image with random valid gaps
    do_reload();
    wr_addr.delete(); wr_data.delete();
    send_stim(3);
    wait_final("gap");
    check("gap done", done, 1'b1);
    check("gap error", error, 1'b0);
    check("gap cpu_reset", cpu_reset, 1'b0);
    check_prog1_writes("gap");

    // Count 0x0401 exceeds 1024-word capacity
    do_reload();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    check("big error", error, 1'b1);
    check("big ready", bus.byte_ready, 1'b0);
    check("big cpu_reset", cpu_reset, 1'b1);
    repeat (3) @(negedge clk);
    check("big no writes", wr_addr.size(), 0);
    @(posedge clk); #1;
    do_reload();

    // Count 0x0400 is exactly capacity; reset after the 5th data byte
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    check("cap error", error, 1'b0);
    check("cap ready", bus.byte_ready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_byte(8'h11 * (i + 1), 0);
    check("pre-rst addr", bus.mem_addr, 1);
    check("pre-rst wdata", bus.mem_wdata, 32'h1122_3344);
    reset = 1'b0;
    #1;
    check("midrst we", bus.mem_we, 1'b0);
    check("midrst addr", bus.mem_addr, 0);
    check("midrst wdata", bus.mem_wdata, 0);
    check("midrst cpu_reset", cpu_reset, 1'b1);
    check("midrst done", done, 1'b0);
    check("midrst error", error, 1'b0);
    check("midrst ready", bus.byte_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    load_prog1();
    wr_addr.delete(); wr_data.delete();
    send_stim(0);
    wait_final("reload-after-rst");
    check("after rst done", done, 1'b1);
    check_prog1_writes("after rst");

    // Empty image
    @(posedge clk); #1;
    do_reload();
    wr_addr.delete(); wr_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge clk);
    check("n0 done", done, 1'b1);
    check("n0 cpu_reset", cpu_reset, 1'b0);
    check("n0 no writes", wr_addr.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good and bad
    @(posedge clk); #1;
    do_reload();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_stim(0);
    wait_final("cs good");
    check("cs good done", done, 1'b1);
    check("cs good error", error, 1'b0);
    @(posedge clk); #1;
    do_reload();
    stim = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_stim(0);
    wait_final("cs bad");
    check("cs bad error", error, 1'b1);
    check("cs bad done", done, 1'b0);
    check("cs bad cpu_reset", cpu_reset, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot loader that fills the CPU's instruction memory from a byte stream and holds the CPU in reset until the image is complete. It sits directly upstream of the CPU's instruction memory write port and reset input, replacing `$readmemh` preloading with a synthesizable load path. It accepts a length-prefixed big-endian word image, writes one 32-bit word per memory write, then releases the CPU.

## Interface
- `ADDR_WIDTH`, 10: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words.
- `clk` input 1: single clock, all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `byte_valid` input 1: `byte_data` is valid this cycle.
- `byte_data` input 8: stream byte.
- `byte_ready` output 1: loader accepts a byte this cycle; a transfer occurs when `byte_valid & byte_ready`.
- `reload` input 1: in DONE or ERR, restarts loading on the next edge.
- `mem_we` output 1: one-cycle instruction-memory write strobe.
- `mem_addr` output ADDR_WIDTH: word address of the current write.
- `mem_wdata` output 32: word to write.
- `cpu_reset` output 1: active-high reset to the CPU; high whenever the image is not loaded.
- `done` output 1: image loaded, CPU released.
- `error` output 1: load aborted, CPU held in reset.

## Operation
- Stream format: count high byte, count low byte, forming 16-bit word count N. This is followed by N words of 4 bytes each, most significant byte first.
- States:
  - CNT_HI: capture the high count byte, then go to CNT_LO.
  - CNT_LO: capture the low count byte. If N == 0, go to DONE, or to CSUM when checksum is enabled. If N > 2^ADDR_WIDTH, go to ERR. Otherwise go to DATA.
  - DATA: shift bytes into a 24-bit assembly register with a 2-bit byte counter.
    - On accepting the 4th byte, load `mem_wdata` with {assembly, byte} and set a write-pending flag.
    - `mem_we` is high for exactly one cycle, driven from that flag.
    - `mem_addr` increments by 1 on the edge ending each `mem_we` cycle.
  - DONE and ERR are terminal until `reload` or reset.
- `byte_ready` is 1 in CNT_HI, CNT_LO, DATA and CSUM, and 0 in DONE and ERR. A byte may be accepted in the same cycle `mem_we` is high; `mem_wdata` stays stable during that cycle.
- A 16-bit word counter tracks words written. After the Nth word's `mem_we` cycle, go to DONE, or to CSUM when checksum is enabled.
- `cpu_reset = !done`. `error` is high only in ERR.
- `reload` is ignored outside DONE and ERR. Taking `reload` clears `mem_addr`, the counters and the assembly register, returns to CNT_HI and reasserts `cpu_reset` on the same edge.
- Instruction memory contents are not cleared; only words 0..N-1 are written.

## Timing
- Reset values:
  - state = CNT_HI
  - `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0
  - `cpu_reset` = 1, `done` = 0, `error` = 0
  - `byte_ready` = 1
- Write latency: `mem_we` is high in the cycle after the 4th byte of a word is accepted.
- Release latency, no checksum: `done` rises and `cpu_reset` falls on the edge that ends the last `mem_we` cycle.
- Release latency, N == 0: `done` rises on the edge after the count-low byte is accepted.
- Throughput: one byte per cycle sustained; gaps in `byte_valid` may occur anywhere without loss.
- Reset mid-load aborts immediately to the reset values. Partially written memory is left as is.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN`
  - Defined: a running 8-bit XOR of all bytes after the count is kept, and the CSUM state accepts one trailing byte. If it equals the running XOR, go to DONE; otherwise go to ERR. With N == 0 the expected checksum is 0x00.
  - Undefined: the CSUM state and XOR logic are absent, and the stream ends after the last data byte.

## Test plan
- Reset asserted, then released with no input: `cpu_reset` = 1, `done` = 0, `byte_ready` = 1, `mem_addr` = 0.
- Stream 00 02 20 08 00 05 AC 08 00 00 at one byte per cycle: two `mem_we` pulses, writing 0x20080005 at address 0 and 0xAC080000 at address 1. `done` = 1 and `cpu_reset` = 0 one edge after the second pulse.
- Same stream with random `byte_valid` gaps: identical writes and final state, and `mem_wdata` stable during each `mem_we` cycle.
- Count 0x0401 with `ADDR_WIDTH` = 10: ERR, `error` = 1, no `mem_we` pulses, `byte_ready` = 0. Then pulse `reload`: returns to CNT_HI with `cpu_reset` = 1.
- With `IMEM_LOADER_CHECKSUM_EN` defined:
  - Stream 00 01 12 34 56 78 08 (XOR = 0x08): DONE.
  - Trailing byte 09 instead: ERR, `cpu_reset` stays 1.
- `reset` driven low after the 5th data byte: all outputs return to reset values on the same edge. A fresh full load afterward succeeds from address 0.
